// File: rtl/cache_l2_nway.sv
//-----------------------------------------------------------------------------
// cache_l2_nway
//
// Parametrised N-way set-associative L2 data cache, one word per line, with
// true LRU replacement. Load hits are served from the arrays; load misses are
// filled through a blocking miss sequence on the memory-side handshake.
// Stores are write-through and write-no-allocate. A flush invalidates one set
// per cycle.
//
// Optional feature (macro L2_PERF_CNT_EN): when defined, hit_count and
// miss_count are saturating counters bumped once per request in LOOKUP.
// When undefined both outputs are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  L1-side request handshake
//   req_we/addr/wdata    request kind, byte address, store data
//   resp_valid/data/hit  one-cycle response pulse, load data, hit flag
//   flush/flush_done     invalidate-all request / one-cycle completion pulse
//   mem_req_*            memory request handshake, kind, address, write data
//   mem_rvalid/rdata     memory read return
//   hit_count/miss_count performance counters
//-----------------------------------------------------------------------------
module cache_l2_nway #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 256,
   parameter int WAYS   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_hit,
   input  logic              flush,
   output logic              flush_done,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam int AGE_W = $clog2(WAYS);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOOKUP   = 3'd1;
   localparam logic [2:0] S_MEM_REQ  = 3'd2;
   localparam logic [2:0] S_MEM_WAIT = 3'd3;
   localparam logic [2:0] S_FILL     = 3'd4;
   localparam logic [2:0] S_FLUSH    = 3'd5;

   logic [2:0]        r_state;
   logic              r_flush_pend;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;          // word-aligned copy of the request address
   logic [DATA_W-1:0] r_wdata;
   logic              r_hit;           // LOOKUP result, reported with the store response
   logic [DATA_W-1:0] r_fill_data;
   logic [IDX_W-1:0]  r_flush_idx;

   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic              r_resp_hit;
   logic              r_flush_done;
   logic              r_mem_req_valid;
   logic              r_mem_req_we;
   logic [ADDR_W-1:0] r_mem_req_addr;
   logic [DATA_W-1:0] r_mem_req_wdata;

   logic [WAYS-1:0]   r_valid [SETS];
   logic [AGE_W-1:0]  r_age   [SETS][WAYS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [DATA_W-1:0] r_data  [SETS][WAYS];

   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic              w_hit;
   logic [AGE_W-1:0]  w_hit_way;
   logic [DATA_W-1:0] w_hit_data;
   logic              w_found_inv;
   logic [AGE_W-1:0]  w_victim;
   logic [AGE_W-1:0]  w_touch_way;
   logic [AGE_W-1:0]  w_new_age [WAYS];
   logic              w_req_ready;
   logic              w_unused;

   assign w_idx    = r_addr[2 +: IDX_W];
   assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
   assign w_unused = ^req_addr[1:0];   // byte offset is irrelevant to a word cache

   // Ready only in IDLE with no flush waiting; a flush in the same cycle wins.
   assign w_req_ready = (r_state == S_IDLE) && !r_flush_pend && !flush && !reset;

   // Tag compare across every way of the indexed set.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_way  = '0;
      w_hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit      = 1'b1;
            w_hit_way  = AGE_W'(w);
            w_hit_data = r_data[w_idx][w];
         end
      end
   end

   // Victim: lowest-index invalid way (descending scan, last match wins),
   // else the least recently used way, i.e. the one with the oldest age.
   always_comb begin
      w_found_inv = 1'b0;
      w_victim    = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_idx][w]) begin
            w_found_inv = 1'b1;
            w_victim    = AGE_W'(w);
         end
      end
      if (!w_found_inv) begin
         for (int w = 0; w < WAYS; w++) begin
            if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) w_victim = AGE_W'(w);
         end
      end
   end

   // LRU update: ways younger than the touched one age by one, touched way
   // becomes 0, so the set's ages remain a permutation of 0..WAYS-1.
   assign w_touch_way = (r_state == S_FILL) ? w_victim : w_hit_way;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_new_age[w] = r_age[w_idx][w];
         if (r_age[w_idx][w] < r_age[w_idx][w_touch_way]) begin
            w_new_age[w] = r_age[w_idx][w] + AGE_W'(1);
         end
      end
      w_new_age[w_touch_way] = '0;
   end

   // Control FSM, valid bits and ages.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_flush_pend    <= 1'b0;
         r_we            <= 1'b0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_hit           <= 1'b0;
         r_fill_data     <= '0;
         r_flush_idx     <= '0;
         r_resp_valid    <= 1'b0;
         r_resp_data     <= '0;
         r_resp_hit      <= 1'b0;
         r_flush_done    <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_we    <= 1'b0;
         r_mem_req_addr  <= '0;
         r_mem_req_wdata <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
         end
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_hit   <= 1'b0;
         r_flush_done <= 1'b0;
         if (flush && (r_state != S_IDLE)) r_flush_pend <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (flush || r_flush_pend) begin
                  r_flush_pend <= 1'b0;
                  r_flush_idx  <= '0;
                  r_state      <= S_FLUSH;
               end else if (req_valid && w_req_ready) begin
                  r_we    <= req_we;
                  r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                  r_wdata <= req_wdata;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_hit <= w_hit;
               if (w_hit) begin
                  for (int w = 0; w < WAYS; w++) r_age[w_idx][w] <= w_new_age[w];
               end
               if (!r_we && w_hit) begin
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= w_hit_data;
                  r_resp_hit   <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_mem_req_valid <= 1'b1;
                  r_mem_req_we    <= r_we;
                  r_mem_req_addr  <= r_addr;
                  r_mem_req_wdata <= r_we ? r_wdata : '0;
                  r_state         <= S_MEM_REQ;
               end
            end
            S_MEM_REQ: begin
               if (mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  if (r_we) begin
                     r_resp_valid <= 1'b1;
                     r_resp_hit   <= r_hit;
                     r_state      <= S_IDLE;
                  end else begin
                     r_state <= S_MEM_WAIT;
                  end
               end
            end
            S_MEM_WAIT: begin
               if (mem_rvalid) begin
                  r_fill_data <= mem_rdata;
                  r_state     <= S_FILL;
               end
            end
            S_FILL: begin
               r_valid[w_idx][w_victim] <= 1'b1;
               for (int w = 0; w < WAYS; w++) r_age[w_idx][w] <= w_new_age[w];
               r_resp_valid <= 1'b1;
               r_resp_data  <= r_fill_data;
               r_state      <= S_IDLE;
            end
            S_FLUSH: begin
               r_valid[r_flush_idx] <= '0;
               for (int w = 0; w < WAYS; w++) r_age[r_flush_idx][w] <= AGE_W'(w);
               if (r_flush_idx == IDX_W'(SETS - 1)) begin
                  r_flush_done <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_flush_idx <= r_flush_idx + IDX_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays.
   // NOTE: these arrays carry no reset; a line is only ever read once its
   // valid bit is set, and leaving them unreset lets them map onto RAM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if ((r_state == S_LOOKUP) && r_we && w_hit) begin
            r_data[w_idx][w_hit_way] <= r_wdata;
         end
         if (r_state == S_FILL) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= r_fill_data;
         end
      end
   end

`ifdef L2_PERF_CNT_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_state == S_LOOKUP) begin
         if (w_hit) begin
            if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
         end else begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

   assign req_ready     = w_req_ready;
   assign resp_valid    = r_resp_valid;
   assign resp_data     = r_resp_data;
   assign resp_hit      = r_resp_hit;
   assign flush_done    = r_flush_done;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_req_we    = r_mem_req_we;
   assign mem_req_addr  = r_mem_req_addr;
   assign mem_req_wdata = r_mem_req_wdata;

endmodule

// File: tb/tb_cache_l2_nway.sv
//-----------------------------------------------------------------------------
// tb_cache_l2_nway
//
// Directed plus randomized stimulus for cache_l2_nway (SETS=256, WAYS=2).
// The reference model is a backing-store map plus a single recency-ordered
// list of resident word addresses (most recent first); a set holds at most
// WAYS entries and the oldest entry of a full set is the one evicted. Because
// stores are write-through, resident data always equals the backing store.
//-----------------------------------------------------------------------------
module tb_cache_l2_nway;

   localparam int SETS   = 256;
   localparam int WAYS   = 2;
   localparam int IDX_W  = 8;
   localparam int BUDGET = 2000;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_hit;
   logic        flush;
   logic        flush_done;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   cache_l2_nway #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_hit      (resp_hit),
      .flush         (flush),
      .flush_done    (flush_done),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int hits   = 0;
   int misses = 0;

   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] lru_q [$];

   logic        h;
   logic [31:0] d;
   logic [31:0] a;
   logic [31:0] wd;
   logic        we;
   logic        fw;
   int          cyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IDX_W-1:0] set_of(input logic [31:0] wa);
      return wa[2 +: IDX_W];
   endfunction

   function automatic bit model_resident(input logic [31:0] wa);
      foreach (lru_q[i]) if (lru_q[i] == wa) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_touch(input logic [31:0] wa);
      int pos;
      int n;
      int last;
      pos = -1;
      foreach (lru_q[i]) if (lru_q[i] == wa) pos = i;
      if (pos >= 0) begin
         lru_q.delete(pos);
      end else begin
         n    = 0;
         last = -1;
         for (int i = 0; i < lru_q.size(); i++) begin
            if (set_of(lru_q[i]) == set_of(wa)) begin
               n++;
               last = i;
            end
         end
         if (n == WAYS) lru_q.delete(last);
      end
      lru_q.push_front(wa);
   endtask

   task automatic model_flush();
      lru_q.delete();
   endtask

   task automatic check_counters(input string tag);
`ifdef L2_PERF_CNT_EN
      check({tag, "_hit_count"},  hit_count,  hits);
      check({tag, "_miss_count"}, miss_count, misses);
`else
      check({tag, "_hit_count"},  hit_count,  0);
      check({tag, "_miss_count"}, miss_count, 0);
`endif
   endtask

   // One request end to end, acting as the memory as well. Called and
   // returning at a negedge; the response negedge is where it returns.
   task automatic do_req(input logic we_i, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_dly, input int rv_dly, input bit flush_in_wait,
                         output logic o_hit, output logic [31:0] o_data);
      logic [31:0] waddr;
      bit          exp_hit;
      logic [31:0] exp_data;
      int          c;
      int          stall;
      int          rv_cnt;
      int          lat;
      bit          got;
      bit          seen;
      bit          hs;
      bit          rv_done;
      bit          stable;
      logic        ready_at_resp;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic        m_we;
      waddr   = {addr[31:2], 2'b00};
      exp_hit = model_resident(waddr);
      if (!mem_m.exists(waddr)) mem_m[waddr] = $urandom;
      exp_data = we_i ? 32'h0 : mem_m[waddr];
      o_hit = 1'b0; o_data = '0; lat = 0; got = 0; seen = 0; hs = 0; rv_done = 0;
      stable = 1; stall = 0; rv_cnt = 0; ready_at_resp = 1'b0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0;

      c = 0;
      while (!req_ready && c < BUDGET) begin @(negedge clk); c++; end
      check("req_ready_wait", req_ready, 1);
      req_valid = 1'b1; req_we = we_i; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

      c = 0;
      while (!got && c < BUDGET) begin
         if (resp_valid) begin
            got = 1; lat = c + 1;
            o_hit = resp_hit; o_data = resp_data; ready_at_resp = req_ready;
         end else begin
            mem_rvalid = 1'b0;
            flush      = 1'b0;
            if (mem_req_valid) begin
               if (!seen) begin
                  seen = 1; m_addr = mem_req_addr; m_we = mem_req_we; m_wdata = mem_req_wdata;
               end else if (mem_req_addr !== m_addr || mem_req_we !== m_we || mem_req_wdata !== m_wdata) begin
                  stable = 0;
               end
               if (req_ready !== 1'b0) stable = 0;
               mem_req_ready = (stall >= rdy_dly);
               stall++;
            end else if (mem_req_ready) begin
               mem_req_ready = 1'b0;
               hs = 1;
            end
            if (hs && !m_we && !rv_done) begin
               rv_cnt++;
               if (flush_in_wait && rv_cnt == 1) flush = 1'b1;
               if (rv_cnt >= rv_dly) begin
                  mem_rvalid = 1'b1; mem_rdata = mem_m[waddr]; rv_done = 1;
               end
            end
            @(negedge clk);
            c++;
         end
      end
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;

      check("resp_seen", got, 1);
      check("resp_hit", o_hit, exp_hit);
      check("resp_data", o_data, exp_data);
      check("mem_stable", stable, 1);
      if (we_i || !exp_hit) begin
         check("mem_req_seen", seen, 1);
         check("mem_req_we", m_we, we_i);
         check("mem_req_addr", m_addr, waddr);
         if (we_i) check("mem_req_wdata", m_wdata, wdata);
      end else begin
         check("hit_no_mem_req", seen, 0);
         check("hit_latency", lat, 2);
      end
      if (!flush_in_wait) check("ready_at_resp", ready_at_resp, 1);

      if (we_i) begin
         mem_m[waddr] = wdata;
         if (exp_hit) model_touch(waddr);
      end else begin
         model_touch(waddr);
      end
      if (exp_hit) hits++; else misses++;
   endtask

   task automatic wait_flush_done(input string tag, input int start);
      int c;
      c = start;
      while (!flush_done && c < BUDGET) begin @(negedge clk); c++; end
      check(tag, c, SETS + 1);
      model_flush();
      @(negedge clk);
      check({tag, "_pulse_end"}, flush_done, 0);
   endtask

   task automatic flush_idle();
      flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400;
      #1;
      check("flush_priority_ready", req_ready, 0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0; req_addr = '0;
      wait_flush_done("flush_idle_cycles", 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      flush = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req_ready",  req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_mem_valid",  mem_req_valid, 0);
      check("rst_mem_addr",   mem_req_addr, 0);
      check("rst_hit_count",  hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", req_ready, 1);

      // Miss fill with read data three cycles after the handshake, then hit
      mem_m[32'h400] = 32'hDEAD_BEEF;
      do_req(1'b0, 32'h400, '0, 0, 3, 1'b0, h, d);
      check("tp1_miss_hit", h, 0);
      check("tp1_miss_data", d, 32'hDEAD_BEEF);
      do_req(1'b0, 32'h400, '0, 0, 1, 1'b0, h, d);
      check("tp1_hit_hit", h, 1);
      check("tp1_hit_data", d, 32'hDEAD_BEEF);

      // LRU eviction in set 0
      do_req(1'b0, 32'h800, '0, 1, 2, 1'b0, h, d);
      do_req(1'b0, 32'h400, '0, 0, 1, 1'b0, h, d);
      do_req(1'b0, 32'hC00, '0, 0, 1, 1'b0, h, d);
      do_req(1'b0, 32'h400, '0, 0, 1, 1'b0, h, d);
      check("tp2_reload_400_hit", h, 1);
      do_req(1'b0, 32'h800, '0, 0, 1, 1'b0, h, d);
      check("tp2_reload_800_hit", h, 0);

      // Write-through store hit and no-allocate store miss
      do_req(1'b1, 32'h400, 32'h1234_5678, 2, 1, 1'b0, h, d);
      check("tp3_store_hit", h, 1);
      do_req(1'b0, 32'h400, '0, 0, 1, 1'b0, h, d);
      check("tp3_reload_hit", h, 1);
      check("tp3_reload_data", d, 32'h1234_5678);
      do_req(1'b1, 32'h1000, 32'hCAFE_0001, 0, 1, 1'b0, h, d);
      check("tp3_store_miss_hit", h, 0);
      do_req(1'b0, 32'h1000, '0, 0, 1, 1'b0, h, d);
      check("tp3_no_allocate", h, 0);

      // Memory stalls five cycles; request must hold steady
      do_req(1'b0, 32'h2006, '0, 5, 2, 1'b0, h, d);

      // Flush during MEM_WAIT: miss completes, then the flush runs
      do_req(1'b0, 32'h3008, '0, 0, 3, 1'b1, h, d);
      wait_flush_done("flush_wait_cycles", 0);
      do_req(1'b0, 32'h400, '0, 0, 1, 1'b0, h, d);
      check("post_flush_400_hit", h, 0);
      do_req(1'b0, 32'h3008, '0, 0, 1, 1'b0, h, d);
      check("post_flush_3008_hit", h, 0);

      // Flush from IDLE with a simultaneous request
      flush_idle();
      do_req(1'b0, 32'h3008, '0, 0, 1, 1'b0, h, d);
      check("post_idle_flush_hit", h, 0);
      check_counters("directed");

      // Randomized traffic over four tags in three sets
      for (int n = 0; n < 150; n++) begin
         a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 2) << 2) | $urandom_range(0, 3);
         we = ($urandom_range(0, 3) == 0);
         wd = $urandom;
         fw = !we && !model_resident({a[31:2], 2'b00}) && ($urandom_range(0, 19) == 0);
         do_req(we, a, wd, $urandom_range(0, 3), $urandom_range(1, 4), fw, h, d);
         if (fw) wait_flush_done("rand_flush_cycles", 0);
      end
      check_counters("random");

      // Reset in the middle of a stalled miss
      cyc = 0;
      while (!req_ready && cyc < BUDGET) begin @(negedge clk); cyc++; end
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h5000;
      @(negedge clk);
      req_valid = 1'b0; req_addr = '0;
      cyc = 0;
      while (!mem_req_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("rst_mid_mem_valid_before", mem_req_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_mem_valid", mem_req_valid, 0);
      check("rst_mid_resp_valid", resp_valid, 0);
      check("rst_mid_hit_count", hit_count, 0);
      check("rst_mid_miss_count", miss_count, 0);
      reset = 1'b0;
      model_flush();
      hits = 0;
      misses = 0;
      @(negedge clk);
      check("rst_mid_ready_after", req_ready, 1);
      check("rst_mid_no_resp", resp_valid, 0);

      // Three hits and two misses for the counters
      do_req(1'b0, 32'h5000, '0, 0, 1, 1'b0, h, d);
      do_req(1'b0, 32'h6004, '0, 0, 2, 1'b0, h, d);
      do_req(1'b0, 32'h5000, '0, 0, 1, 1'b0, h, d);
      do_req(1'b0, 32'h6004, '0, 0, 1, 1'b0, h, d);
      do_req(1'b0, 32'h5000, '0, 0, 1, 1'b0, h, d);
      check("perf_hits_model", hits, 3);
      check_counters("perf");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
